sdio_rx_data_deser: RTL and testbench
=====================================

SDIO_RX_DATA_DESER -- requirements
Module: sdio_rx_data_deser

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024, giving the maximum wait for a start bit in clk_i cycles.
REQ-002 SHALL have parameter BSIZE_W, default 10, giving the block-size field width.
REQ-003 clk_i  input  1  single clock (SD card clock domain); all logic rising-edge.
REQ-004 rst_i  input  1  reset, synchronous, active-high.
REQ-005 start_i  input  1  one-cycle pulse arming a multi-block read.
REQ-006 quad_i  input  1  1 = 4-bit bus (sddata_i[3:0]), 0 = 1-bit bus (sddata_i[0]).
REQ-007 block_size_i  input  BSIZE_W  bytes per block minus 1.
REQ-008 block_num_i  input  8  blocks minus 1.
REQ-009 sddata_i  input  4  card data lines, sampled every clk_i.
REQ-010 data_o  output  32  received word.
REQ-011 valid_o  output  1  data_o valid.
REQ-012 ready_i  input  1  downstream (RX dual-clock FIFO) accepts the word.
REQ-013 busy_o  output  1  transfer in progress.
REQ-014 eot_o  output  1  one-cycle end-of-transfer pulse.
REQ-015 err_crc_o  output  1  sticky CRC/stop-bit error, cleared on start_i.
REQ-016 err_timeout_o  output  1  sticky start-bit timeout, cleared on start_i.
REQ-017 err_ovf_o  output  1  sticky output overflow, cleared on start_i.

Function
REQ-018 FSM states SHALL be IDLE, WAIT_START, DATA, CRC, STOP.
REQ-019 IDLE -> WAIT_START on start_i: latch quad_i, block_size_i and block_num_i; clear the error flags and the timeout counter.
REQ-020 start_i SHALL be ignored when busy_o=1; busy_o=1 in every state except IDLE.
REQ-021 WAIT_START -> DATA when all active lines are 0 (the start bit).
- Timeout counter increments each cycle.
- At TIMEOUT_CYCLES-1 without a start bit: set err_timeout_o, pulse eot_o, go to IDLE.
REQ-022 DATA SHALL shift bits MSB-first.
- 1-bit mode: 8 cycles per byte.
- 4-bit mode: 2 cycles per byte, high nibble first, sddata_i[3] = MSB.
REQ-023 Bytes SHALL pack little-endian: first byte of a word -> data_o[7:0].
- A word is emitted after 4 bytes, or at the last byte of a block.
- A partial final word is zero-padded in its upper bytes.
REQ-024 Emitted word: data_o/valid_o are registered and appear the cycle after the last bit of the word; valid_o holds until ready_i=1.
REQ-025 If a new word completes while valid_o=1 and ready_i=0: set err_ovf_o, overwrite data_o, keep valid_o=1 (the card clock cannot stall).
REQ-026 After byte block_size_i: DATA -> CRC for 16 cycles.
- One CRC16 per active line (4 in quad, 1 otherwise).
- Polynomial x^16+x^12+x^5+1, init 0x0000, computed over that line's data bits.
REQ-027 CRC -> STOP for 1 cycle; any active line at 0 sets err_crc_o.
REQ-028 STOP -> WAIT_START (timeout reset) if the block counter != block_num_i; otherwise -> IDLE with an eot_o pulse in the same cycle.
REQ-029 Errors other than timeout SHALL NOT abort the transfer; all blocks are still received.
REQ-030 block_size_i=0 SHALL give 1-byte blocks, each emitting one word with data_o[31:8]=0.

Reset
REQ-031 While rst_i=1, at the next edge:
- state=IDLE.
- data_o=0, valid_o=0, busy_o=0, eot_o=0, all error flags=0.
- All counters and CRC registers=0.
REQ-032 rst_i mid-transfer SHALL abort with no eot_o pulse; a pending valid_o is dropped.

Configuration
REQ-033 Macro SDIO_RX_CRC_CHECK_EN defined: CRC per REQ-026; mismatch against the received 16 bits on any active line sets err_crc_o at the end of the CRC state.
REQ-034 Macro undefined: no CRC logic; CRC bits are counted and discarded; err_crc_o set only by the stop-bit check; timing identical.

Verification
REQ-035 1-bit, block_size_i=3, block_num_i=0, bytes 0x11,0x22,0x33,0x44, correct CRC, ready_i=1 -> one word 0x44332211; eot_o pulse; no errors.
REQ-036 Quad, block_size_i=511, block_num_i=1, incrementing bytes, correct CRCs -> 256 words, first 0x03020100; one eot_o; no errors.
REQ-037 Quad, line 2 CRC bit flipped -> err_crc_o=1 with macro defined, 0 without; all words still delivered; eot_o pulses.
REQ-038 Lines held at 0xF after start_i, TIMEOUT_CYCLES=16 -> err_timeout_o=1 and eot_o 16 cycles after WAIT_START entry; busy_o=0 next cycle.
REQ-039 1-bit, block_size_i=7, ready_i=0 throughout -> err_ovf_o=1 when the second word completes; data_o = second word.
REQ-040 rst_i asserted mid-DATA -> next cycle all outputs 0, no eot_o; a new start_i then completes normally.

Source files
------------

// File: rtl/sdio_rx_data_deser.sv
// -----------------------------------------------------------------------------
// sdio_rx_data_deser
//
// Receives multi-block read data from an SD/SDIO card data bus in 1-bit or
// 4-bit mode and repacks it into 32-bit little-endian words for a downstream
// RX FIFO.
//
// Per block, the bus carries:
//   - a start bit,
//   - block_size+1 bytes, MSB first,
//   - 16 CRC bits per active line,
//   - one stop bit.
//
// Optional feature macro: SDIO_RX_CRC_CHECK_EN
//   defined   : a CRC16 (x^16+x^12+x^5+1, init 0) is computed per active line
//               and compared against the received CRC bits.
//   undefined : the CRC bits are only counted and discarded. Timing is
//               identical in both builds.
//
// Ports
//   clk_i          card clock; all logic runs on its rising edge
//   rst_i          synchronous active-high reset
//   start_i        one-cycle pulse that arms a transfer (ignored while busy)
//   quad_i         1 = 4-bit bus, 0 = 1-bit bus (sddata_i[0])
//   block_size_i   bytes per block minus 1
//   block_num_i    blocks minus 1
//   sddata_i       card data lines
//   data_o/valid_o received word; valid_o holds until ready_i
//   ready_i        downstream accepts the word
//   busy_o         transfer in progress
//   eot_o          one-cycle end-of-transfer pulse
//   err_crc_o      sticky CRC / stop-bit error
//   err_timeout_o  sticky start-bit timeout
//   err_ovf_o      sticky output overflow
// -----------------------------------------------------------------------------
module sdio_rx_data_deser #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int BSIZE_W        = 10
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               start_i,
  input  logic               quad_i,
  input  logic [BSIZE_W-1:0] block_size_i,
  input  logic [7:0]         block_num_i,
  input  logic [3:0]         sddata_i,
  output logic [31:0]        data_o,
  output logic               valid_o,
  input  logic               ready_i,
  output logic               busy_o,
  output logic               eot_o,
  output logic               err_crc_o,
  output logic               err_timeout_o,
  output logic               err_ovf_o
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [2:0] {
    IDLE,
    WAIT_START,
    DATA,
    CRC,
    STOP
  } state_t;

  state_t state_q, state_d;

  logic               quad_q;
  logic [BSIZE_W-1:0] bsize_q;
  logic [7:0]         bnum_q;
  logic [TW-1:0]      tcnt_q;
  logic [2:0]         bit_cnt_q;
  logic [BSIZE_W-1:0] byte_cnt_q;
  logic [7:0]         blk_cnt_q;
  logic [3:0]         crc_cnt_q;
  logic [7:0]         byte_q;
  logic [31:0]        word_q;
  logic [1:0]         wbyte_q;
  logic [31:0]        data_q;
  logic               valid_q;
  logic               eot_q;
  logic               err_crc_q;
  logic               err_timeout_q;
  logic               err_ovf_q;

  logic        start_bit;
  logic        any_low;
  logic        timeout_hit;
  logic        byte_last_bit;
  logic        byte_done;
  logic        block_last;
  logic        word_done;
  logic        blk_last;
  logic        crc_last;
  logic        crc_bad;
  logic [7:0]  byte_next;
  logic [31:0] word_next;

  // Bus decode: only line 0 is considered in 1-bit mode.
  assign start_bit   = quad_q ? (sddata_i == 4'h0) : ~sddata_i[0];
  assign any_low     = quad_q ? (sddata_i != 4'hF) : ~sddata_i[0];
  assign timeout_hit = (state_q == WAIT_START) && !start_bit &&
                       (tcnt_q == TW'(TIMEOUT_CYCLES - 1));

  // A byte takes 2 cycles on the quad bus and 8 cycles on the single-line bus.
  assign byte_last_bit = quad_q ? bit_cnt_q[0] : (bit_cnt_q == 3'd7);
  assign byte_next     = quad_q ? {byte_q[3:0], sddata_i} : {byte_q[6:0], sddata_i[0]};
  assign byte_done     = (state_q == DATA) && byte_last_bit;
  assign block_last    = byte_done && (byte_cnt_q == bsize_q);
  assign word_done     = byte_done && ((wbyte_q == 2'd3) || (byte_cnt_q == bsize_q));
  assign blk_last      = (blk_cnt_q == bnum_q);
  assign crc_last      = (crc_cnt_q == 4'd15);

  // The accumulator is cleared after every emitted word, so a short final word
  // is automatically zero in its upper bytes.
  assign word_next = word_q | ({24'h0, byte_next} << {wbyte_q, 3'b000});

`ifdef SDIO_RX_CRC_CHECK_EN
  logic [3:0] crc_mis;

  for (genvar gi = 0; gi < 4; gi++) begin : g_crc
    logic [15:0] crc_q;
    logic [14:0] rxcrc_q;
    logic        fb;

    assign fb = sddata_i[gi] ^ crc_q[15];

    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        crc_q   <= '0;
        rxcrc_q <= '0;
      end else if (state_q == WAIT_START) begin
        crc_q   <= '0;
        rxcrc_q <= '0;
      end else if (state_q == DATA) begin
        crc_q <= {crc_q[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end else if (state_q == CRC) begin
        rxcrc_q <= {rxcrc_q[13:0], sddata_i[gi]};
      end
    end

    // The last received CRC bit is still on the line in the final CRC cycle.
    assign crc_mis[gi] = ({rxcrc_q, sddata_i[gi]} != crc_q);
  end

  assign crc_bad = (state_q == CRC) && crc_last && (quad_q ? |crc_mis : crc_mis[0]);
`else
  assign crc_bad = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (start_i) state_d = WAIT_START;
      end
      WAIT_START: begin
        if (start_bit)        state_d = DATA;
        else if (timeout_hit) state_d = IDLE;
      end
      DATA: begin
        if (block_last) state_d = CRC;
      end
      CRC: begin
        if (crc_last) state_d = STOP;
      end
      STOP: begin
        state_d = blk_last ? IDLE : WAIT_START;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      quad_q        <= 1'b0;
      bsize_q       <= '0;
      bnum_q        <= '0;
      tcnt_q        <= '0;
      bit_cnt_q     <= '0;
      byte_cnt_q    <= '0;
      blk_cnt_q     <= '0;
      crc_cnt_q     <= '0;
      byte_q        <= '0;
      word_q        <= '0;
      wbyte_q       <= '0;
      data_q        <= '0;
      valid_q       <= 1'b0;
      eot_q         <= 1'b0;
      err_crc_q     <= 1'b0;
      err_timeout_q <= 1'b0;
      err_ovf_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      eot_q   <= 1'b0;
      if (valid_q && ready_i) valid_q <= 1'b0;

      case (state_q)
        IDLE: begin
          if (start_i) begin
            quad_q        <= quad_i;
            bsize_q       <= block_size_i;
            bnum_q        <= block_num_i;
            tcnt_q        <= '0;
            blk_cnt_q     <= '0;
            err_crc_q     <= 1'b0;
            err_timeout_q <= 1'b0;
            err_ovf_q     <= 1'b0;
          end
        end
        WAIT_START: begin
          if (start_bit) begin
            bit_cnt_q  <= '0;
            byte_cnt_q <= '0;
            wbyte_q    <= '0;
            word_q     <= '0;
          end else if (timeout_hit) begin
            err_timeout_q <= 1'b1;
            eot_q         <= 1'b1;
          end else begin
            tcnt_q <= tcnt_q + TW'(1);
          end
        end
        DATA: begin
          byte_q    <= byte_next;
          bit_cnt_q <= byte_last_bit ? 3'd0 : bit_cnt_q + 3'd1;
          if (byte_last_bit) begin
            if (word_done) begin
              // The card clock cannot be stalled, so an unaccepted word is
              // overwritten and the loss is flagged.
              if (valid_q && !ready_i) err_ovf_q <= 1'b1;
              data_q  <= word_next;
              valid_q <= 1'b1;
              word_q  <= '0;
              wbyte_q <= '0;
            end else begin
              word_q  <= word_next;
              wbyte_q <= wbyte_q + 2'd1;
            end
            if (block_last) crc_cnt_q <= '0;
            else            byte_cnt_q <= byte_cnt_q + BSIZE_W'(1);
          end
        end
        CRC: begin
          crc_cnt_q <= crc_cnt_q + 4'd1;
          if (crc_bad) err_crc_q <= 1'b1;
        end
        STOP: begin
          if (any_low) err_crc_q <= 1'b1;
          if (blk_last) begin
            eot_q <= 1'b1;
          end else begin
            blk_cnt_q <= blk_cnt_q + 8'd1;
            tcnt_q    <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy_o        = (state_q != IDLE);
  assign data_o        = data_q;
  assign valid_o       = valid_q;
  assign eot_o         = eot_q;
  assign err_crc_o     = err_crc_q;
  assign err_timeout_o = err_timeout_q;
  assign err_ovf_o     = err_ovf_q;

endmodule

// File: tb/tb_sdio_rx_data_deser.sv
// -----------------------------------------------------------------------------
// tb_sdio_rx_data_deser
//
// Directed bench for sdio_rx_data_deser (TIMEOUT_CYCLES=16). Inputs change 2
// time units after each rising edge. Outputs are read there as well, or by the
// word/eot monitor on the falling edge.
// -----------------------------------------------------------------------------
module tb_sdio_rx_data_deser;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_i;
  logic        quad_i;
  logic [9:0]  block_size_i;
  logic [7:0]  block_num_i;
  logic [3:0]  sd;
  logic [31:0] data_o;
  logic        valid_o;
  logic        ready_i;
  logic        busy_o;
  logic        eot_o;
  logic        err_crc_o;
  logic        err_timeout_o;
  logic        err_ovf_o;

  int          errors = 0;
  int          checks = 0;
  int          eot_cnt = 0;
  logic [31:0] got[$];
  logic [7:0]  blk [512];
  logic        crc_flip_exp;

  sdio_rx_data_deser #(
    .TIMEOUT_CYCLES(16),
    .BSIZE_W       (10)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start_i),
    .quad_i       (quad_i),
    .block_size_i (block_size_i),
    .block_num_i  (block_num_i),
    .sddata_i     (sd),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .busy_o       (busy_o),
    .eot_o        (eot_o),
    .err_crc_o    (err_crc_o),
    .err_timeout_o(err_timeout_o),
    .err_ovf_o    (err_ovf_o)
  );

  always #5 clk = ~clk;

  // Collect accepted words and end-of-transfer pulses.
  always @(negedge clk) begin
    if (valid_o && ready_i) got.push_back(data_o);
    if (eot_o) eot_cnt <= eot_cnt + 1;
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%h expected=%h", tag, obs, exp);
      $error("check %s did not match", tag);
    end
  endtask

  function automatic logic [31:0] gw(input int i);
    if (i < got.size()) return got[i];
    return 32'hxxxx_xxxx;
  endfunction

  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic b);
    logic fb;
    fb = b ^ c[15];
    return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
  endfunction

  function automatic logic [31:0] errs();
    return {29'h0, err_crc_o, err_timeout_o, err_ovf_o};
  endfunction

  task automatic start_xfer(input bit q, input int bs, input int bn);
    eot_cnt = 0;
    got.delete();
    step();
    start_i      = 1'b1;
    quad_i       = q;
    block_size_i = bs[9:0];
    block_num_i  = bn[7:0];
    step();
    start_i = 1'b0;
  endtask

  // Drive one block from blk[]: start bit, data, CRC (optionally one bit of
  // line 'flip' inverted), stop bit. Returns early before byte 'abort_at'.
  task automatic send_block(input int n, input bit q, input int flip,
                            input bit bad_stop, input int abort_at);
    logic [15:0] c [4];
    logic [7:0]  b;
    for (int i = 0; i < 4; i++) c[i] = 16'h0;
    step();
    sd = q ? 4'h0 : 4'hE;
    for (int k = 0; k < n; k++) begin
      if (k == abort_at) return;
      b = blk[k];
      if (q) begin
        for (int h = 1; h >= 0; h--) begin
          step();
          sd = b[h*4 +: 4];
          for (int i = 0; i < 4; i++) c[i] = crc_upd(c[i], sd[i]);
        end
      end else begin
        for (int j = 7; j >= 0; j--) begin
          step();
          sd = {3'b111, b[j]};
          c[0] = crc_upd(c[0], b[j]);
        end
      end
    end
    for (int k = 15; k >= 0; k--) begin
      step();
      for (int i = 0; i < 4; i++) sd[i] = c[i][k] ^ ((i == flip) && (k == 7));
      if (!q) sd[3:1] = 3'b111;
    end
    step();
    sd = bad_stop ? 4'hE : 4'hF;
    step();
    sd = 4'hF;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy_o && n < 200) begin
      step();
      n++;
    end
    chk(tag, {31'h0, busy_o}, 32'h0);
    step();
  endtask

  initial begin
`ifdef SDIO_RX_CRC_CHECK_EN
    crc_flip_exp = 1'b1;
`else
    crc_flip_exp = 1'b0;
`endif
    rst = 1'b1; start_i = 1'b0; quad_i = 1'b0; block_size_i = '0;
    block_num_i = '0; sd = 4'hF; ready_i = 1'b1;
    repeat (3) step();

    // Reset state
    chk("rst_data", data_o, 32'h0);
    chk("rst_flags", {27'h0, valid_o, busy_o, eot_o, err_crc_o, err_timeout_o}, 32'h0);
    chk("rst_ovf", {31'h0, err_ovf_o}, 32'h0);
    rst = 1'b0;
    step();

    // 1-bit, 4 bytes, one block
    blk[0] = 8'h11; blk[1] = 8'h22; blk[2] = 8'h33; blk[3] = 8'h44;
    start_xfer(0, 3, 0);
    chk("t1_busy", {31'h0, busy_o}, 32'h1);
    send_block(4, 0, -1, 0, -1);
    wait_idle("t1_idle");
    chk("t1_nwords", got.size(), 32'd1);
    chk("t1_word", gw(0), 32'h4433_2211);
    chk("t1_eot", eot_cnt, 32'd1);
    chk("t1_errs", errs(), 32'h0);
    $display("t1: word=%h eot=%0d", gw(0), eot_cnt);

    // Quad, 2 blocks of 512 incrementing bytes
    for (int i = 0; i < 512; i++) blk[i] = i[7:0];
    start_xfer(1, 511, 1);
    send_block(512, 1, -1, 0, -1);
    send_block(512, 1, -1, 0, -1);
    wait_idle("t2_idle");
    chk("t2_nwords", got.size(), 32'd256);
    chk("t2_first", gw(0), 32'h0302_0100);
    for (int k = 0; k < 256; k++) begin
      logic [7:0] b0;
      b0 = 8'((k % 128) * 4);
      chk("t2_word", gw(k), {b0 + 8'd3, b0 + 8'd2, b0 + 8'd1, b0});
    end
    chk("t2_eot", eot_cnt, 32'd1);
    chk("t2_errs", errs(), 32'h0);
    $display("t2: words=%0d last=%h eot=%0d", got.size(), gw(255), eot_cnt);

    // Quad, CRC bit flipped on line 2
    for (int i = 0; i < 8; i++) blk[i] = 8'hA0 + 8'(i);
    start_xfer(1, 7, 0);
    send_block(8, 1, 2, 0, -1);
    wait_idle("t3_idle");
    chk("t3_w0", gw(0), 32'hA3A2_A1A0);
    chk("t3_w1", gw(1), 32'hA7A6_A5A4);
    chk("t3_crc", {31'h0, err_crc_o}, {31'h0, crc_flip_exp});
    chk("t3_eot", eot_cnt, 32'd1);
    $display("t3: err_crc=%0d eot=%0d", err_crc_o, eot_cnt);

    // 1-bit, 1-byte blocks, second block with bad stop bit
    start_xfer(0, 0, 1);
    chk("t4_crc_clr", {31'h0, err_crc_o}, 32'h0);
    blk[0] = 8'hA5;
    send_block(1, 0, -1, 0, -1);
    blk[0] = 8'h5A;
    send_block(1, 0, -1, 1, -1);
    wait_idle("t4_idle");
    chk("t4_w0", gw(0), 32'h0000_00A5);
    chk("t4_w1", gw(1), 32'h0000_005A);
    chk("t4_errs", errs(), 32'h4);
    chk("t4_eot", eot_cnt, 32'd1);
    $display("t4: w0=%h w1=%h errs=%h", gw(0), gw(1), errs());

    // Overflow: ready low throughout
    for (int i = 0; i < 8; i++) blk[i] = 8'h01 + 8'(i);
    ready_i = 1'b0;
    start_xfer(0, 7, 0);
    send_block(8, 0, -1, 0, -1);
    wait_idle("t5_idle");
    chk("t5_valid", {31'h0, valid_o}, 32'h1);
    chk("t5_data", data_o, 32'h0807_0605);
    chk("t5_errs", errs(), 32'h1);
    chk("t5_eot", eot_cnt, 32'd1);
    ready_i = 1'b1;
    step();
    chk("t5_drain", {31'h0, valid_o}, 32'h0);
    $display("t5: data=%h errs=%h", data_o, errs());

    // Start-bit timeout; a start_i pulse while busy must be ignored
    start_xfer(0, 3, 0);
    for (int i = 1; i <= 15; i++) begin
      step();
      if (i == 4) start_i = 1'b1;
      if (i == 5) start_i = 1'b0;
    end
    chk("t6_eot_early", {31'h0, eot_o}, 32'h0);
    step();
    chk("t6_eot", {31'h0, eot_o}, 32'h1);
    chk("t6_errs", errs(), 32'h2);
    step();
    chk("t6_busy", {30'h0, busy_o, eot_o}, 32'h0);
    $display("t6: err_timeout=%0d busy=%0d", err_timeout_o, busy_o);

    // Reset in the middle of DATA with a word pending
    ready_i = 1'b0;
    start_xfer(0, 7, 0);
    send_block(8, 0, -1, 0, 5);
    chk("t7_pend", data_o, 32'h0403_0201);
    sd = 4'hF;
    rst = 1'b1;
    step();
    chk("t7_data", data_o, 32'h0);
    chk("t7_flags", {26'h0, valid_o, busy_o, eot_o, err_crc_o, err_timeout_o, err_ovf_o}, 32'h0);
    rst = 1'b0;
    ready_i = 1'b1;
    step();
    step();
    chk("t7_no_eot", eot_cnt, 32'd0);
    blk[0] = 8'hDE; blk[1] = 8'hAD; blk[2] = 8'hBE; blk[3] = 8'hEF;
    start_xfer(0, 3, 0);
    send_block(4, 0, -1, 0, -1);
    wait_idle("t7_idle");
    chk("t7_word", gw(0), 32'hEFBE_ADDE);
    chk("t7_eot", eot_cnt, 32'd1);
    chk("t7_errs", errs(), 32'h0);
    $display("t7: word=%h eot=%0d", gw(0), eot_cnt);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
